// File: rtl/store_narrow.sv
// Store-path narrowing unit: checks alignment and signed-truncation overflow of a
// 32-bit store operand, then writes the selected bytes little-endian, one per beat.
module store_narrow #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              trunc_ovf,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       data_q;
  logic [1:0]        idx_q, last_q;
  logic              err_q, ovf_q;

  logic              req_err, req_ovf;
  logic [1:0]        req_last;

  // Request decode, only consumed on the cycle start is accepted in IDLE.
  always_comb begin
    req_err  = (size == 2'b11) |
               ((size == 2'b01) & addr[0]) |
               ((size == 2'b10) & (addr[1:0] != 2'b00));
    req_last = 2'd3;
    req_ovf  = 1'b0;
    case (size)
      2'b00: begin
        req_last = 2'd0;
        req_ovf  = ~((&wdata[31:7]) | ~(|wdata[31:7]));
      end
      2'b01: begin
        req_last = 2'd1;
        req_ovf  = ~((&wdata[31:15]) | ~(|wdata[31:15]));
      end
      default: begin
        req_last = 2'd3;
        req_ovf  = 1'b0;
      end
    endcase
    if (req_err) req_ovf = 1'b0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = req_err ? FIN : WRITE;
      WRITE:   if (mem_ready && (idx_q == last_q)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) begin
        base_q <= addr;
        data_q <= wdata;
        last_q <= req_last;
        idx_q  <= '0;
        err_q  <= req_err;
        ovf_q  <= req_ovf;
      end else if ((state == WRITE) && mem_ready && (idx_q != last_q)) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Memory-side outputs are forced to zero outside WRITE so reset/idle read as 0.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    err       = err_q;
    trunc_ovf = ovf_q;
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = base_q + ADDR_W'(idx_q);
      mem_wdata = data_q[{idx_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow: beat order, stalls, error and
// overflow flags, ignored starts, and asynchronous reset mid-store.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, trunc_ovf, mem_we, mem_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  int errors = 0;
  int checks = 0;

  int          nlog, done_at, busy_bad;
  int          lg_t[16];
  logic [31:0] lg_a[16];
  logic [7:0]  lg_d[16];
  logic        lg_r[16];
  logic        d_err, d_ovf;

  store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .trunc_ovf(trunc_ovf),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one store at the current cycle and logs every beat until done.
  // stall[t] = 1 drives mem_ready low during cycle N+t.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [15:0] stall,
                           input bit poke_start);
    start = 1'b1; size = sz; addr = a; wdata = d; mem_ready = 1'b0;
    nlog = 0; done_at = 0; busy_bad = 0; d_err = 1'b0; d_ovf = 1'b0;
    step();
    start = 1'b0; size = 2'b11; addr = 32'hDEAD_BEEF; wdata = 32'h5555_AAAA;
    for (int t = 1; t <= 20; t++) begin
      mem_ready = ~stall[t % 16];
      start = poke_start;
      if (!busy) busy_bad++;
      if (mem_we && nlog < 16) begin
        lg_t[nlog] = t; lg_a[nlog] = mem_addr; lg_d[nlog] = mem_wdata;
        lg_r[nlog] = mem_ready; nlog++;
      end
      if (done) begin
        done_at = t; d_err = err; d_ovf = trunc_ovf;
        break;
      end
      step();
    end
    start = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, trunc_ovf, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b ovf=%b we=%b addr=%h data=%h, want all 0",
               busy, done, err, trunc_ovf, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_word();
    logic [7:0] exp_d[4];
    exp_d = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_store(2'b10, 32'h100, 32'h1234_5678, 16'h0, 1'b0);
    checks++;
    if (nlog !== 4) begin errors++; $display("FAIL word_beats: got %0d want 4", nlog); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lg_t[i] !== i + 1 || lg_a[i] !== 32'h100 + i || lg_d[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL word_beat%0d: got t=%0d (%h,%h) want t=%0d (%h,%h)",
                 i, lg_t[i], lg_a[i], lg_d[i], i + 1, 32'h100 + i, exp_d[i]);
      end
    end
    checks++;
    if (done_at !== 5 || d_err !== 1'b0 || d_ovf !== 1'b0 || busy_bad !== 0) begin
      errors++;
      $display("FAIL word_done: got done_at=%0d err=%b ovf=%b busy_bad=%0d want 5 0 0 0",
               done_at, d_err, d_ovf, busy_bad);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL word_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_byte();
    logic [31:0] vals[2];
    logic        exp_ovf[2];
    vals = '{32'hFFFF_FF80, 32'h0000_0080};
    exp_ovf = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      run_store(2'b00, 32'h7, vals[k], 16'h0, 1'b0);
      checks++;
      if (nlog !== 1 || lg_t[0] !== 1 || lg_a[0] !== 32'h7 || lg_d[0] !== 8'h80) begin
        errors++;
        $display("FAIL byte_beat%0d: got n=%0d t=%0d (%h,%h) want 1 1 (00000007,80)",
                 k, nlog, lg_t[0], lg_a[0], lg_d[0]);
      end
      checks++;
      if (done_at !== 2 || d_err !== 1'b0 || d_ovf !== exp_ovf[k]) begin
        errors++;
        $display("FAIL byte_done%0d: got done_at=%0d err=%b ovf=%b want 2 0 %b",
                 k, done_at, d_err, d_ovf, exp_ovf[k]);
      end
    end
  endtask

  task automatic test_half_stall();
    int          exp_t[4];
    logic [31:0] exp_a[4];
    logic [7:0]  exp_d[4];
    logic        exp_r[4];
    exp_t = '{1, 2, 3, 4};
    exp_a = '{32'h202, 32'h202, 32'h202, 32'h203};
    exp_d = '{8'hCD, 8'hCD, 8'hCD, 8'hAB};
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b1};
    run_store(2'b01, 32'h202, 32'h0000_ABCD, 16'b0000_0000_0000_0110, 1'b0);
    checks++;
    if (nlog !== 4) begin errors++; $display("FAIL half_beats: got %0d want 4", nlog); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lg_t[i] !== exp_t[i] || lg_a[i] !== exp_a[i] || lg_d[i] !== exp_d[i] ||
          lg_r[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL half_beat%0d: got t=%0d (%h,%h) want t=%0d (%h,%h)",
                 i, lg_t[i], lg_a[i], lg_d[i], exp_t[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (done_at !== 5 || d_err !== 1'b0 || d_ovf !== 1'b1) begin
      errors++;
      $display("FAIL half_done: got done_at=%0d err=%b ovf=%b want 5 0 1", done_at, d_err, d_ovf);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz[4];
    logic [31:0] ad[4];
    sz = '{2'b01, 2'b10, 2'b11, 2'b10};
    ad = '{32'h201, 32'h102, 32'h0, 32'hFFFF_FFFE};
    for (int k = 0; k < 4; k++) begin
      run_store(sz[k], ad[k], 32'h1234_5678, 16'h0, 1'b0);
      checks++;
      if (nlog !== 0 || done_at !== 1 || d_err !== 1'b1 || d_ovf !== 1'b0) begin
        errors++;
        $display("FAIL misaligned%0d: got beats=%0d done_at=%0d err=%b ovf=%b want 0 1 1 0",
                 k, nlog, done_at, d_err, d_ovf);
      end
    end
  endtask

  task automatic test_top_byte();
    run_store(2'b00, 32'hFFFF_FFFF, 32'h0000_005A, 16'h0, 1'b0);
    checks++;
    if (nlog !== 1 || lg_a[0] !== 32'hFFFF_FFFF || lg_d[0] !== 8'h5A ||
        done_at !== 2 || d_err !== 1'b0 || d_ovf !== 1'b0) begin
      errors++;
      $display("FAIL top_byte: got n=%0d (%h,%h) done_at=%0d err=%b ovf=%b want 1 (ffffffff,5a) 2 0 0",
               nlog, lg_a[0], lg_d[0], done_at, d_err, d_ovf);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_d[4];
    exp_d = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    run_store(2'b10, 32'h300, 32'hA1B2_C3D4, 16'h0, 1'b1);
    checks++;
    if (nlog !== 4 || done_at !== 5) begin
      errors++; $display("FAIL poke_count: got beats=%0d done_at=%0d want 4 5", nlog, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lg_a[i] !== 32'h300 + i || lg_d[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL poke_beat%0d: got (%h,%h) want (%h,%h)",
                 i, lg_a[i], lg_d[i], 32'h300 + i, exp_d[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL poke_queued: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_midstore();
    int saw_done;
    saw_done = 0;
    start = 1'b1; size = 2'b10; addr = 32'h400; wdata = 32'hCAFE_F00D; mem_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h402 || mem_wdata !== 8'hFE) begin
      errors++;
      $display("FAIL rst_third_beat: got we=%b (%h,%h) want 1 (00000402,fe)", mem_we, mem_addr, mem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, trunc_ovf, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b done=%b we=%b addr=%h data=%h want all 0",
               busy, done, mem_we, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done++;
    end
    rst_n = 1'b1;
    step();
    if (done) saw_done++;
    checks++;
    if (saw_done !== 0) begin
      errors++; $display("FAIL rst_no_done: got %0d done cycles want 0", saw_done);
    end
    run_store(2'b00, 32'h10, 32'h0000_0033, 16'h0, 1'b0);
    checks++;
    if (nlog !== 1 || lg_a[0] !== 32'h10 || lg_d[0] !== 8'h33 || done_at !== 2) begin
      errors++;
      $display("FAIL rst_recover: got n=%0d (%h,%h) done_at=%0d want 1 (00000010,33) 2",
               nlog, lg_a[0], lg_d[0], done_at);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = '0; wdata = '0; mem_ready = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_word();
    test_byte();
    test_half_stall();
    test_misaligned();
    test_top_byte();
    test_start_ignored();
    test_reset_midstore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
